vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Slot-based VRAM arbiter: a 4-slot frame shared between display fetch, CPU and DMA.
// Every grant runs through a fixed 3-stage pipeline, so each access acks 3 cycles after its grant.
module vram_arbiter #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_en,
  input  logic          vid_sync,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic [7:0]    dma_dout,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_DMA  = 2'd3;

  logic [1:0]    slot_q, slot_d;
  logic          rr_q, rr_d;
  logic          cpuPend_q, cpuPend_d;
  logic          dmaPend_q, dmaPend_d;
  logic [1:0]    own1_q, own2_q;
  logic          we1_q, we2_q;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic          memWe_q, memWe_d;
  logic [7:0]    memDin_q, memDin_d;
  logic          vidValid_q;
  logic          cpuAck_q, dmaAck_q;
  logic [7:0]    cpuDout_q, dmaDout_q;
  logic [1:0]    grant;
  logic          cpuElig, dmaElig, sharedSlot;

  assign cpuElig    = cpu_req & ~cpuPend_q;
  assign dmaElig    = dma_req & ~dmaPend_q;
  assign sharedSlot = (slot_q == 2'd3) || ((slot_q == 2'd0) && !vid_en);

  // rr=0 favours DMA on a contended shared slot, rr=1 favours CPU; it flips only on contention.
  always_comb begin
    grant = OWN_NONE;
    rr_d  = rr_q;
    if ((slot_q == 2'd0) && vid_en) begin
      grant = OWN_VID;
    end else if (sharedSlot) begin
      if (cpuElig && dmaElig) begin
        grant = rr_q ? OWN_CPU : OWN_DMA;
        rr_d  = ~rr_q;
      end else if (cpuElig) begin
        grant = OWN_CPU;
      end else if (dmaElig) begin
        grant = OWN_DMA;
      end
    end else if (slot_q == 2'd1) begin
      if (cpuElig)      grant = OWN_CPU;
      else if (dmaElig) grant = OWN_DMA;
    end else begin
      if (dmaElig)      grant = OWN_DMA;
      else if (cpuElig) grant = OWN_CPU;
    end
  end

  always_comb begin
    memAddr_d = memAddr_q;
    memDin_d  = memDin_q;
    memWe_d   = 1'b0;
    case (grant)
      OWN_VID: memAddr_d = vid_addr;
      OWN_CPU: begin
        memAddr_d = cpu_addr;
        memDin_d  = cpu_din;
        memWe_d   = cpu_we;
      end
      OWN_DMA: begin
        memAddr_d = dma_addr;
        memDin_d  = dma_din;
        memWe_d   = dma_we;
      end
      OWN_NONE: ;
    endcase
  end

  // A pending flag drops as its ack is registered, so the requester is eligible in the ack cycle.
  assign slot_d    = vid_sync ? 2'd0 : slot_q + 2'd1;
  assign cpuPend_d = (cpuPend_q && (own2_q != OWN_CPU)) || (grant == OWN_CPU);
  assign dmaPend_d = (dmaPend_q && (own2_q != OWN_DMA)) || (grant == OWN_DMA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q     <= 2'd0;
      rr_q       <= 1'b0;
      cpuPend_q  <= 1'b0;
      dmaPend_q  <= 1'b0;
      own1_q     <= OWN_NONE;
      own2_q     <= OWN_NONE;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      memAddr_q  <= '0;
      memWe_q    <= 1'b0;
      memDin_q   <= 8'h00;
      vidValid_q <= 1'b0;
      cpuAck_q   <= 1'b0;
      dmaAck_q   <= 1'b0;
      cpuDout_q  <= 8'h00;
      dmaDout_q  <= 8'h00;
    end else begin
      slot_q     <= slot_d;
      rr_q       <= rr_d;
      cpuPend_q  <= cpuPend_d;
      dmaPend_q  <= dmaPend_d;
      own1_q     <= grant;
      we1_q      <= memWe_d;
      own2_q     <= own1_q;
      we2_q      <= we1_q;
      memAddr_q  <= memAddr_d;
      memWe_q    <= memWe_d;
      memDin_q   <= memDin_d;
      vidValid_q <= (own1_q == OWN_VID);
      cpuAck_q   <= (own2_q == OWN_CPU);
      dmaAck_q   <= (own2_q == OWN_DMA);
      if ((own2_q == OWN_CPU) && !we2_q) cpuDout_q <= mem_dout;
      if ((own2_q == OWN_DMA) && !we2_q) dmaDout_q <= mem_dout;
    end
  end

  assign mem_addr  = memAddr_q;
  assign mem_we    = memWe_q;
  assign mem_din   = memDin_q;
  assign vid_valid = vidValid_q;
  assign cpu_ack   = cpuAck_q;
  assign dma_ack   = dmaAck_q;
  assign cpu_dout  = cpuDout_q;
  assign dma_dout  = dmaDout_q;

endmodule
